// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared types and helpers for the request/acknowledge scheduler
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Timestamp width: two bits of headroom over the latency range keep equality compares wrap-safe.
  function automatic int tw_of(input int max_lat);
    return $clog2(max_lat) + 2;
  endfunction

  function automatic int clamp_lat(input int v, input int max_lat);
    if (v < 1) return 1;
    if (v > max_lat) return max_lat;
    return v;
  endfunction

endpackage

// File: rtl/due_fifo.sv
// rtl/due_fifo.sv - circular FIFO of due timestamps with head and head+1 visibility
module due_fifo
  import req_ack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [W-1:0]               head_nxt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A full FIFO still takes a push when it pops in the same cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[bump(rd_ptr)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= bump(wr_ptr);
      if (pop_ok)  rd_ptr <= bump(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/req_ack_scheduler.sv
// rtl/req_ack_scheduler.sv - issues b_ack exactly cur_lat cycles after each accepted a_req
module req_ack_scheduler
  import req_ack_pkg::*;
#(
  parameter int MAX_LAT = 15,
  parameter int MAX_OUT = 4,
  parameter int DEF_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         a_req,
  input  logic [$clog2(MAX_LAT+1)-1:0] cfg_lat,
  input  logic                         cfg_load,
  input  logic                         err_clr,
  output logic                         b_ack,
  output logic                         busy,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [$clog2(MAX_LAT+1)-1:0] cur_lat,
  output logic                         ovf_err,
  output logic                         drop_err
);

  localparam int LW = $clog2(MAX_LAT+1);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int TW = tw_of(MAX_LAT);

  state_t        state;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_p1;
  logic [LW-1:0] pend_lat;
  logic          pend_q;
  logic [LW-1:0] cfg_clamped;

  logic [TW-1:0] head;
  logic [TW-1:0] head_nxt;
  logic [OW-1:0] count;
  logic          full;
  logic          empty;

  logic          pop;
  logic          admit_ok;
  logic          accept;
  logic          drop_ev;
  logic          ovf_ev;
  logic          empties;
  logic          ack_d;

  assign cfg_clamped = LW'(clamp_lat(int'(cfg_lat), MAX_LAT));
  assign cnt_p1      = cnt + TW'(1);

  // An entry leaves the queue on its due cycle; b_ack is registered one cycle earlier.
  assign pop      = !empty && (head == cnt);
  // A cfg_load strobe blocks acceptance so cur_lat never changes with a request in flight.
  assign admit_ok = (state == RUN) && en && !pend_q && !cfg_load;
  assign accept   = a_req && admit_ok && (!full || pop);
  assign drop_ev  = a_req && !admit_ok;
  assign ovf_ev   = a_req && admit_ok && full && !pop;
  assign empties  = empty || ((count == OW'(1)) && pop);

  assign ack_d = (!empty && (head == cnt_p1))
              || (pop && (count > OW'(1)) && (head_nxt == cnt_p1))
              || (accept && (cur_lat == LW'(1)));

  assign outstanding = count;
  assign busy        = !empty;

  due_fifo #(
    .DEPTH(MAX_OUT),
    .W    (TW)
  ) u_due_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .din     (cnt + TW'(cur_lat)),
    .pop     (pop),
    .head    (head),
    .head_nxt(head_nxt),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      b_ack    <= 1'b0;
      cur_lat  <= LW'(DEF_LAT);
      pend_q   <= 1'b0;
      pend_lat <= LW'(DEF_LAT);
      ovf_err  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      cnt      <= cnt_p1;
      b_ack    <= ack_d;
      ovf_err  <= (ovf_err && !err_clr) || ovf_ev;
      drop_err <= (drop_err && !err_clr) || drop_ev;
      case (state)
        IDLE: begin
          if (cfg_load) cur_lat <= cfg_clamped;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!empty && (!en || cfg_load)) begin
            state <= DRAIN;
            if (cfg_load) begin
              pend_q   <= 1'b1;
              pend_lat <= cfg_clamped;
            end
          end else begin
            if (cfg_load) cur_lat <= cfg_clamped;
            if (!en) state <= IDLE;
          end
        end
        DRAIN: begin
          if (empties) begin
            if (cfg_load)    cur_lat <= cfg_clamped;
            else if (pend_q) cur_lat <= pend_lat;
            pend_q <= 1'b0;
            state  <= en ? RUN : IDLE;
          end else if (cfg_load) begin
            pend_q   <= 1'b1;
            pend_lat <= cfg_clamped;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_scheduler.sv
// tb/tb_req_ack_scheduler.sv - scoreboard bench for req_ack_scheduler against a timestamp model
module tb_req_ack_scheduler;

  localparam int MAX_LAT = 15;
  localparam int MAX_OUT = 4;
  localparam int DEF_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       a_req = 1'b0;
  logic       cfg_load = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] cfg_lat = 4'd0;
  logic       b_ack;
  logic       busy;
  logic       ovf_err;
  logic       drop_err;
  logic [2:0] outstanding;
  logic [3:0] cur_lat;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  bit started = 0;

  // Model: absolute cycle numbers of pending completions and of expected acks.
  int dues[$];
  int ackq[$];
  int m_mode = 0;
  int m_lat = DEF_LAT;
  int m_pend = -1;
  bit m_ovf = 0;
  bit m_drop = 0;

  req_ack_scheduler #(
    .MAX_LAT(MAX_LAT),
    .MAX_OUT(MAX_OUT),
    .DEF_LAT(DEF_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .a_req      (a_req),
    .cfg_lat    (cfg_lat),
    .cfg_load   (cfg_load),
    .err_clr    (err_clr),
    .b_ack      (b_ack),
    .busy       (busy),
    .outstanding(outstanding),
    .cur_lat    (cur_lat),
    .ovf_err    (ovf_err),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  function automatic int clampf(input int v);
    return (v < 1) ? 1 : ((v > MAX_LAT) ? MAX_LAT : v);
  endfunction

  task automatic model_reset();
    dues.delete();
    ackq.delete();
    m_mode = 0;
    m_lat  = DEF_LAT;
    m_pend = -1;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  task automatic model_step();
    int  n;
    int  old_lat;
    int  c;
    bit  popping;
    bit  admit;
    bit  acc;
    bit  empties;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n       = dues.size();
    old_lat = m_lat;
    c       = clampf(int'(cfg_lat));
    popping = (n > 0) && (dues[0] == cyc);
    admit   = (m_mode == 1) && en && (m_pend < 0) && !cfg_load;
    acc     = a_req && admit && ((n < MAX_OUT) || popping);
    empties = (n == 0) || ((n == 1) && popping);
    m_ovf   = (m_ovf && !err_clr) || (a_req && admit && !acc);
    m_drop  = (m_drop && !err_clr) || (a_req && !admit);
    if (acc) ackq.push_back(cyc + old_lat - 1);
    case (m_mode)
      0: begin
        if (cfg_load) m_lat = c;
        if (en) m_mode = 1;
      end
      1: begin
        if ((n > 0) && (!en || cfg_load)) begin
          m_mode = 2;
          if (cfg_load) m_pend = c;
        end else begin
          if (cfg_load) m_lat = c;
          if (!en) m_mode = 0;
        end
      end
      default: begin
        if (empties) begin
          if (cfg_load) m_lat = c;
          else if (m_pend >= 0) m_lat = m_pend;
          m_pend = -1;
          m_mode = en ? 1 : 0;
        end else if (cfg_load) begin
          m_pend = c;
        end
      end
    endcase
    if (popping) void'(dues.pop_front());
    if (acc) dues.push_back(cyc + old_lat);
  endtask

  task automatic check_outputs();
    chk("outstanding", int'(outstanding), dues.size());
    chk("busy", int'(busy), (dues.size() != 0) ? 1 : 0);
    chk("cur_lat", int'(cur_lat), m_lat);
    chk("ovf_err", int'(ovf_err), int'(m_ovf));
    chk("drop_err", int'(drop_err), int'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (started && rst_n) begin
      while (ackq.size() > 0 && ackq[0] < cyc) begin
        total++;
        $display("FAIL ack_missing for cycle %0d: b_ack=0 expected 1", ackq[0]);
        void'(ackq.pop_front());
      end
      if (b_ack) begin
        total++;
        if (ackq.size() > 0 && ackq[0] == cyc) begin
          passed++;
          void'(ackq.pop_front());
        end else begin
          $display("FAIL ack_unexpected at cycle %0d: b_ack=1 expected 0", cyc);
        end
      end
    end
  end

  initial begin
    ticks(3);
    rst_n = 1'b1;
    en = 1'b1;
    started = 1;

    // Single request at the default latency.
    tick();
    a_req = 1'b1; tick();
    a_req = 1'b0; ticks(8);

    // Four back-to-back then a fifth that rides on the first pop.
    a_req = 1'b1; ticks(5);
    a_req = 1'b0; tick();
    chk("no_ovf_on_pop", int'(ovf_err), 0);
    ticks(8);

    // Longer latency makes a five-request burst overflow.
    cfg_load = 1'b1; cfg_lat = 4'd7; tick();
    cfg_load = 1'b0;
    a_req = 1'b1; ticks(5);
    a_req = 1'b0; tick();
    chk("ovf_set", int'(ovf_err), 1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("ovf_clr", int'(ovf_err), 0);
    ticks(12);

    // Latency change while a request is pending forces a drain.
    cfg_load = 1'b1; cfg_lat = 4'd4; tick();
    cfg_load = 1'b0;
    chk("lat_4", int'(cur_lat), 4);
    a_req = 1'b1; tick();
    a_req = 1'b0; cfg_load = 1'b1; cfg_lat = 4'd7; tick();
    cfg_load = 1'b0; a_req = 1'b1; tick();
    a_req = 1'b0;
    chk("drop_set", int'(drop_err), 1);
    ticks(4);
    chk("lat_7_after_drain", int'(cur_lat), 7);
    a_req = 1'b1; tick();
    a_req = 1'b0; ticks(10);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;

    // Clamping in idle and minimum latency.
    en = 1'b0; tick();
    cfg_load = 1'b1; cfg_lat = 4'd0; tick();
    cfg_load = 1'b0;
    chk("clamp_0", int'(cur_lat), 1);
    en = 1'b1; tick();
    a_req = 1'b1; tick();
    a_req = 1'b0; ticks(3);
    cfg_load = 1'b1; cfg_lat = 4'd15; tick();
    cfg_load = 1'b0;
    chk("lat_15", int'(cur_lat), 15);

    // Mid-cycle reset with requests in flight.
    a_req = 1'b1; ticks(3);
    a_req = 1'b0; tick();
    chk("pre_reset_out", int'(outstanding), 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_b_ack", int'(b_ack), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_lat", int'(cur_lat), DEF_LAT);
    chk("rst_errs", int'(ovf_err) + int'(drop_err), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(20);
    a_req = 1'b1; tick();
    a_req = 1'b0; ticks(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 19) != 0);
      a_req    = ($urandom_range(0, 9) < 6);
      cfg_load = ($urandom_range(0, 24) == 0);
      cfg_lat  = 4'($urandom_range(0, 15));
      err_clr  = ($urandom_range(0, 19) == 0);
      tick();
    end

    en = 1'b0; a_req = 1'b0; cfg_load = 1'b0; err_clr = 1'b0;
    ticks(30);
    chk("ack_queue_drained", ackq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
